// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 keystream blocks (generator and XOR stream).
package rc4_pkg;

  localparam int BYTE_W        = 8;
  // Keystream bytes per generator ckey word; the generator uses the same default.
  localparam int NUMS_OF_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } xor_state_e;

endpackage

// File: rtl/rc4_ks_fifo.sv
// Keystream word FIFO. Flush has priority over a same-cycle push or pop.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module rc4_ks_fifo #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WORD_W-1:0] wdata,
  input  logic              pop,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [WORD_W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              do_push, do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  // Full blocks a push even if a pop frees a slot in the same cycle.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Storage array; no reset needed, contents are only read when non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rc4_xor_stream.sv
// RC4 keystream consumer: buffers keystream words, serialises them byte by
// byte and XORs each byte with one plaintext byte under valid/ready.
// Optional macro RC4_XOR_STATS_EN adds a saturating ciphertext handshake
// counter on port ct_count.
module rc4_xor_stream #(
  parameter int NUMS_OF_BYTES = rc4_pkg::NUMS_OF_BYTES,
  parameter int FIFO_DEPTH    = 4,
  parameter int LEN_W         = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [LEN_W-1:0]           msg_len,
  input  logic                       ks_flush,
  input  logic                       ks_valid,
  output logic                       ks_ready,
  input  logic [NUMS_OF_BYTES*8-1:0] ks_data,
  input  logic                       pt_valid,
  output logic                       pt_ready,
  input  logic [7:0]                 pt_data,
  output logic                       ct_valid,
  input  logic                       ct_ready,
  output logic [7:0]                 ct_data,
  output logic                       busy,
  output logic                       done
`ifdef RC4_XOR_STATS_EN
  ,
  output logic [31:0]                ct_count
`endif
);
  import rc4_pkg::*;

  localparam int WORD_W = NUMS_OF_BYTES * BYTE_W;
  localparam int LANE_W = (NUMS_OF_BYTES > 1) ? $clog2(NUMS_OF_BYTES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUMS_OF_BYTES - 1);

  xor_state_e                             state;
  logic [LEN_W-1:0]                       remaining;
  logic [LANE_W-1:0]                      lane;
  logic                                   fifo_full, fifo_empty, fifo_pop;
  logic                                   pt_accept, ct_hs;
  logic [WORD_W-1:0]                      head;
  logic [NUMS_OF_BYTES-1:0][BYTE_W-1:0]   head_bytes;

  rc4_ks_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_ks_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ks_valid && ks_ready),
    .wdata (ks_data),
    .pop   (fifo_pop),
    .flush (ks_flush),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  // Byte 0 of the word sits in bits [7:0] and is consumed first.
  assign head_bytes = head;
  assign ks_ready   = !fifo_full;
  assign pt_ready   = (state == RUN) && (remaining != '0) && !fifo_empty &&
                      (!ct_valid || ct_ready);
  assign pt_accept  = pt_valid && pt_ready;
  assign ct_hs      = ct_valid && ct_ready;
  assign fifo_pop   = pt_accept && (lane == LAST_LANE);
  assign busy       = (state == RUN);
  assign done       = (state == FIN);

  // Message FSM: remaining counts plaintext bytes still to accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          remaining <= msg_len;
          state     <= (msg_len == '0) ? FIN : RUN;
        end
        RUN: begin
          if (pt_accept) remaining <= remaining - 1'b1;
          // With nothing left to accept, the byte in ct_data is the last one.
          if (ct_hs && remaining == '0) state <= FIN;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Lane pointer into the head word; persists across messages until flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             lane <= '0;
    else if (ks_flush)      lane <= '0;
    else if (pt_accept)     lane <= (lane == LAST_LANE) ? '0 : lane + 1'b1;
  end

  // Ciphertext output register; holds until the sink takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ct_valid <= 1'b0;
      ct_data  <= '0;
    end else if (pt_accept) begin
      ct_valid <= 1'b1;
      ct_data  <= pt_data ^ head_bytes[lane];
    end else if (ct_ready) begin
      ct_valid <= 1'b0;
    end
  end

`ifdef RC4_XOR_STATS_EN
  // Saturating count of ciphertext handshakes since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        ct_count <= '0;
    else if (ct_hs && ct_count != '1)  ct_count <= ct_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_rc4_xor_stream.sv
// Directed bench for rc4_xor_stream with a byte-level keystream model and a
// ciphertext scoreboard.
`timescale 1ns/1ps
module tb_rc4_xor_stream;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, ks_flush = 1'b0, ks_valid = 1'b0;
  logic        pt_valid = 1'b0, ct_ready = 1'b1;
  logic [15:0] msg_len = '0;
  logic [31:0] ks_data = '0;
  logic [7:0]  pt_data = '0;
  logic        ks_ready, pt_ready, ct_valid, busy, done;
  logic [7:0]  ct_data;
`ifdef RC4_XOR_STATS_EN
  logic [31:0] ct_count;
`endif

  int vectors = 0, errors = 0;
  logic [7:0] ks_q[$];   // keystream bytes the DUT should still hold, in order
  logic [7:0] exp_q[$];  // ciphertext bytes expected, in order

  rc4_xor_stream dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msg_len(msg_len),
    .ks_flush(ks_flush), .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
    .busy(busy), .done(done)
`ifdef RC4_XOR_STATS_EN
    , .ct_count(ct_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every ciphertext handshake must match the model.
  always @(negedge clk) begin
    if (rst_n && ct_valid && ct_ready) begin
      check("ct_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("ct_data", ct_data, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic int words();
    return (ks_q.size() + 3) / 4;
  endfunction

  task automatic push_word(input logic [31:0] w);
    ks_valid = 1'b1; ks_data = w;
    @(negedge clk);
    check("ks_ready", ks_ready, words() < 4);
    if (words() < 4) for (int i = 0; i < 4; i++) ks_q.push_back(w[8*i +: 8]);
    tick();
    ks_valid = 1'b0;
  endtask

  task automatic start_msg(input int len);
    start = 1'b1; msg_len = 16'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic send_pt(input logic [7:0] b);
    bit ok = 1'b0;
    pt_valid = 1'b1; pt_data = b;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (pt_ready) begin
        ok = 1'b1;
        exp_q.push_back(b ^ ks_q.pop_front());
        tick();
      end
    end
    pt_valid = 1'b0;
    check("pt_accept_in_time", ok, 1'b1);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    check(tag, seen, 1'b1);
    tick();
    @(negedge clk);
    check("done_single_pulse", done, 1'b0);
    check("exp_drained", exp_q.size(), 0);
    tick();
  endtask

  task automatic run_msg(input logic [7:0] pts[$], input string tag);
    start_msg(pts.size());
    foreach (pts[i]) send_pt(pts[i]);
    wait_done(tag);
  endtask

  initial begin
    logic [7:0] p[$];
    #2;
    // Reset values
    check("rst_ks_ready", ks_ready, 1'b1);
    check("rst_pt_ready", pt_ready, 1'b0);
    check("rst_ct_valid", ct_valid, 1'b0);
    check("rst_ct_data", ct_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic word: 10,20,30,40 ^ 11,22,33,44 -> 01,02,03,04
    push_word(32'h44332211);
    p = '{8'h10, 8'h20, 8'h30, 8'h40};
    run_msg(p, "basic_done");

    // Carry-over: two 2-byte messages share one word
    push_word(32'h44332211);
    p = '{8'h00, 8'h00};
    run_msg(p, "carry1_done");
    push_word(32'hA3A2A1A0);
    push_word(32'hB3B2B1B0);
    push_word(32'hC3C2C1C0);
    @(negedge clk);
    check("carry_head_not_popped", ks_ready, 1'b0);
    tick();
    run_msg(p, "carry2_done");
    @(negedge clk);
    check("carry_head_popped", ks_ready, 1'b1);
    tick();

    // FIFO full: 4th word fills it, 5th is held off until a pop
    push_word(32'hD3D2D1D0);
    ks_valid = 1'b1; ks_data = 32'hE3E2E1E0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_blocks_push", ks_ready, 1'b0);
      tick();
    end
    ks_valid = 1'b0;
    p = '{};
    for (int i = 0; i < 4; i++) p.push_back(8'($urandom_range(0, 255)));
    run_msg(p, "full_msg_done");
    push_word(32'hE3E2E1E0);

    // Backpressure: ct_ready low for 5 cycles mid-message
    start_msg(4);
    send_pt(8'h5A);
    send_pt(8'hC3);
    ct_ready = 1'b0;
    pt_valid = 1'b1; pt_data = 8'h77;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_pt_ready", pt_ready, 1'b0);
      check("bp_ct_valid", ct_valid, 1'b1);
      check("bp_ct_stable", ct_data, exp_q[0]);
      tick();
    end
    ct_ready = 1'b1;
    send_pt(8'h77);
    send_pt(8'h99);
    wait_done("bp_done");

    // Zero length: done the cycle after start, no ciphertext
    start_msg(0);
    @(negedge clk);
    check("zero_done", done, 1'b1);
    check("zero_ct_valid", ct_valid, 1'b0);
    check("zero_busy", busy, 1'b0);
    tick();
    @(negedge clk);
    check("zero_done_clear", done, 1'b0);
    tick();

    // Flush with words buffered; same-cycle push is dropped
    ks_flush = 1'b1; ks_valid = 1'b1; ks_data = 32'hDEADBEEF;
    tick();
    ks_flush = 1'b0; ks_valid = 1'b0;
    ks_q.delete();
    start_msg(2);
    @(negedge clk);
    check("flush_stall_pt_ready", pt_ready, 1'b0);
    check("flush_busy", busy, 1'b1);
    tick();
    push_word(32'h1234A55A);
    send_pt(8'h0F);
    send_pt(8'hF0);
    wait_done("flush_done");

    // Async reset mid-message
    push_word(32'h87654321);
    ct_ready = 1'b0;
    start_msg(4);
    send_pt(8'h3C);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ct_valid", ct_valid, 1'b0);
    check("arst_ct_data", ct_data, 8'h00);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_pt_ready", pt_ready, 1'b0);
    check("arst_ks_ready", ks_ready, 1'b1);
    exp_q.delete();
    ks_q.delete();
    ct_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("arst_no_done", done, 1'b0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
